// File: rtl/draw_pkg.sv
// draw_pkg: definitions shared by the sprite draw sequencer and its pixel mux.
//   draw_state_t  - sequencer FSM state encoding
//   TRANSP_COLOUR - colour code drawers use for "no pixel here"
//   dir_t         - sprite direction codes used by the drawers
package draw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_GRANT   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } draw_state_t;

  localparam logic [5:0] TRANSP_COLOUR = 6'h3F;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

endpackage

// File: rtl/draw_pixel_mux.sv
// draw_pixel_mux: selects the granted drawer's pixel from the packed source
// buses, drops transparent pixels, and registers the result for the VGA port.
//   clock, reset     - system clock, synchronous active-high reset
//   grant            - sequencer is in GRANT this cycle
//   sel              - index of the granted drawer
//   src_x/y/colour   - packed per-drawer pixel buses (source i at [i*W +: W])
//   src_write        - per-drawer write strobes
//   vga_x/y/colour   - registered pixel, holds its last value outside GRANT
//   vga_write        - registered write enable, 0 outside GRANT
module draw_pixel_mux
  import draw_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int XW    = 9,
  parameter int YW    = 8,
  parameter int CW    = 6,
  parameter int SW    = 2,
  parameter logic [CW-1:0] TRANSP = CW'(TRANSP_COLOUR)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                grant,
  input  logic [SW-1:0]       sel,
  input  logic [N_SRC*XW-1:0] src_x,
  input  logic [N_SRC*YW-1:0] src_y,
  input  logic [N_SRC*CW-1:0] src_colour,
  input  logic [N_SRC-1:0]    src_write,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                vga_write
);

  logic [XW-1:0] pix_x_s;
  logic [YW-1:0] pix_y_s;
  logic [CW-1:0] pix_colour_s;
  logic          pix_write_s;

  // Slice the granted drawer's pixel out of the packed buses.
  always_comb begin
    pix_x_s      = src_x[int'(sel)*XW +: XW];
    pix_y_s      = src_y[int'(sel)*YW +: YW];
    pix_colour_s = src_colour[int'(sel)*CW +: CW];
    pix_write_s  = src_write[sel] && (pix_colour_s != TRANSP);
  end

  // Output register: coordinates track the granted drawer, writes only in GRANT.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_x      <= {XW{1'b0}};
      vga_y      <= {YW{1'b0}};
      vga_colour <= {CW{1'b0}};
      vga_write  <= 1'b0;
    end else if (grant) begin
      vga_x      <= pix_x_s;
      vga_y      <= pix_y_s;
      vga_colour <= pix_colour_s;
      vga_write  <= pix_write_s;
    end else begin
      vga_write  <= 1'b0;
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: once per frame_tick, grants draw_req to each enabled drawer
// in index order (higher index paints over lower), waits for its done or a
// timeout, and forwards the granted drawer's pixels to the VGA adapter.
//   clock, reset       - system clock, synchronous active-high reset
//   frame_tick         - one-cycle frame start pulse
//   src_en / src_done  - per-drawer enable and draw_done
//   src_x/y/colour     - packed per-drawer pixel buses
//   src_write          - per-drawer VGA write strobe
//   draw_req           - one-hot grant, 0 when not granting
//   vga_x/y/colour/write - registered pixel output
//   busy, frame_done   - frame in progress / one-cycle completion pulse
//   timeout_err, overrun_err - sticky error flags, cleared only by reset
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int N_SRC   = 3,
  parameter int TIMEOUT = 1024,
  parameter int XW      = 9,
  parameter int YW      = 8,
  parameter int CW      = 6,
  parameter logic [CW-1:0] TRANSP = CW'(TRANSP_COLOUR)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [N_SRC-1:0]    src_en,
  input  logic [N_SRC-1:0]    src_done,
  input  logic [N_SRC*XW-1:0] src_x,
  input  logic [N_SRC*YW-1:0] src_y,
  input  logic [N_SRC*CW-1:0] src_colour,
  input  logic [N_SRC-1:0]    src_write,
  output logic [N_SRC-1:0]    draw_req,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [CW-1:0]       vga_colour,
  output logic                vga_write,
  output logic                busy,
  output logic                frame_done,
  output logic                timeout_err,
  output logic                overrun_err
);

  // idx needs one extra bit so it can step past the last drawer.
  localparam int IW = $clog2(N_SRC) + 1;
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0]    IDX_LAST = IW'(N_SRC - 1);
  localparam logic [IW-1:0]    IDX_END  = IW'(N_SRC);
  localparam logic [TW-1:0]    CNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [N_SRC-1:0] REQ_ONE  = N_SRC'(1);

  draw_state_t   state_r;
  logic [IW-1:0] idx_r;
  logic [TW-1:0] cnt_r;
  logic [SW-1:0] idx_sel_s;
  logic          grant_s;

  // Clamp idx so the bus selects never reach past the last drawer.
  always_comb begin
    if (idx_r < IDX_END) begin
      idx_sel_s = idx_r[SW-1:0];
    end else begin
      idx_sel_s = {SW{1'b0}};
    end
    grant_s = (state_r == ST_GRANT);
  end

  // Frame sequencing FSM with all control outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= {IW{1'b0}};
      cnt_r       <= {TW{1'b0}};
      draw_req    <= {N_SRC{1'b0}};
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A tick outside IDLE (DONE included) is flagged and otherwise ignored.
      if (frame_tick && (state_r != ST_IDLE)) begin
        overrun_err <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (frame_tick) begin
            state_r <= ST_SCAN;
            idx_r   <= {IW{1'b0}};
            busy    <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (idx_r >= IDX_END) begin
            state_r    <= ST_DONE;
            frame_done <= 1'b1;
          end else if (src_en[idx_sel_s]) begin
            state_r  <= ST_GRANT;
            cnt_r    <= {TW{1'b0}};
            draw_req <= REQ_ONE << idx_sel_s;
          end else begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            // Skipping the last drawer ends the frame without an extra scan.
            if (idx_r == IDX_LAST) begin
              state_r    <= ST_DONE;
              frame_done <= 1'b1;
            end
          end
        end
        ST_GRANT: begin
          cnt_r <= cnt_r + {{(TW-1){1'b0}}, 1'b1};
          if (src_done[idx_sel_s]) begin
            state_r  <= ST_RELEASE;
            draw_req <= {N_SRC{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= ST_RELEASE;
            draw_req    <= {N_SRC{1'b0}};
            timeout_err <= 1'b1;
          end
        end
        ST_RELEASE: begin
          // One idle cycle lets the drawer see draw_req low and drop its done.
          state_r <= ST_SCAN;
          idx_r   <= idx_r + {{(IW-1){1'b0}}, 1'b1};
          cnt_r   <= {TW{1'b0}};
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          draw_req <= {N_SRC{1'b0}};
          busy     <= 1'b0;
        end
      endcase
    end
  end

  draw_pixel_mux #(
    .N_SRC (N_SRC),
    .XW    (XW),
    .YW    (YW),
    .CW    (CW),
    .SW    (SW),
    .TRANSP(TRANSP)
  ) u_pixel_mux (
    .clock     (clock),
    .reset     (reset),
    .grant     (grant_s),
    .sel       (idx_sel_s),
    .src_x     (src_x),
    .src_y     (src_y),
    .src_colour(src_colour),
    .src_write (src_write),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_write (vga_write)
  );

endmodule
